ex_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with its own Hi/Lo register pair. It serves the EX stage of the pipelined core and is the next generation of the single-cycle HiLo path. It accepts one operation per Start pulse, runs a radix-2 shift-add multiply or a restoring divide over DATA_W cycles, and raises Stall to the hazard logic while results are pending. It also executes MTHI/MTLO and supplies MFHI/MFLO read data.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_hilo_reg.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state and decode helpers for the EX multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package muldiv_pkg;
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  // Quotient returned on divide by zero; sliced down to DATA_W (<= 64).
  localparam logic [63:0] QUOT_ONES = '1;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  function automatic logic isAcc(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic isSubAcc(input logic [3:0] op);
    return isAcc(op) && ((op == OP_MSUB) || (op == OP_MSUBU));
  endfunction

  function automatic logic isMul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || isAcc(op);
  endfunction

  function automatic logic isDiv(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSigned(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction
endpackage

// File: rtl/muldiv_hilo_reg.sv
// Hi/Lo architectural register pair with independent write enables.
module muldiv_hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              hiWe,
  input  logic              loWe,
  input  logic [DATA_W-1:0] hiD,
  input  logic [DATA_W-1:0] loD,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else begin
      if (hiWe) Hi <= hiD;
      if (loWe) Lo <= loD;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with Hi/Lo, for the EX stage.
// MULDIV_MADD_EN adds the multiply-accumulate ops and their accumulate adder.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Cancel,
  input  logic [3:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              RdReq,
  input  logic              RdSel,
  output logic [DATA_W-1:0] ReadData,
  output logic              Busy,
  output logic              Stall,
  output logic              Done,
  output logic              DivByZero,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          opR;
  logic                sA, sB, dz;
  logic [DATA_W-1:0]   wHi, wLo, opnd;
  logic [DATA_W-1:0]   nHi, nLo, fixHi, fixLo, absA, absB, hiD, loD;
  logic [DATA_W:0]     mulSum, divSh, divDiff;
  logic [2*DATA_W-1:0] prod;
  logic                accept, signedOp, fixWr, hiWe, loWe;

  assign accept   = (state == IDLE) & Start & ~Cancel;
  assign signedOp = isSigned(Op);
  assign absA     = (signedOp & A[DATA_W-1]) ? -A : A;
  assign absB     = (signedOp & B[DATA_W-1]) ? -B : B;
  assign Busy     = (state != IDLE);
  assign Stall    = Busy & (Start | RdReq);
  assign ReadData = RdSel ? Hi : Lo;

  // One iteration: mul accumulates into wHi and shifts the multiplier out of wLo;
  // div shifts the dividend from wLo into the partial remainder wHi.
  always_comb begin
    mulSum  = {1'b0, wHi} + {1'b0, (wLo[0] ? opnd : {DATA_W{1'b0}})};
    divSh   = {wHi, wLo[DATA_W-1]};
    divDiff = divSh - {1'b0, opnd};
    if (isDiv(opR)) begin
      nHi = divDiff[DATA_W] ? divSh[DATA_W-1:0] : divDiff[DATA_W-1:0];
      nLo = {wLo[DATA_W-2:0], ~divDiff[DATA_W]};
    end else begin
      nHi = mulSum[DATA_W:1];
      nLo = {mulSum[0], wLo[DATA_W-1:1]};
    end
  end

  always_comb begin
    prod = {wHi, wLo};
    if (sA ^ sB) prod = -prod;
    fixHi = prod[2*DATA_W-1:DATA_W];
    fixLo = prod[DATA_W-1:0];
    if (dz) begin
      fixHi = wHi;
      fixLo = wLo;
    end else if (isDiv(opR)) begin
      fixLo = (sA ^ sB) ? -wLo : wLo;
      fixHi = sA ? -wHi : wHi;
    end
`ifdef MULDIV_MADD_EN
    else if (isAcc(opR)) begin
      {fixHi, fixLo} = isSubAcc(opR) ? ({Hi, Lo} - prod) : ({Hi, Lo} + prod);
    end
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opR       <= '0;
      sA        <= 1'b0;
      sB        <= 1'b0;
      dz        <= 1'b0;
      wHi       <= '0;
      wLo       <= '0;
      opnd      <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) DivByZero <= 1'b0;
          if (accept && (isMul(Op) || isDiv(Op))) begin
            opR <= Op;
            sA  <= signedOp & A[DATA_W-1];
            sB  <= signedOp & B[DATA_W-1];
            wHi <= '0;
            dz  <= 1'b0;
            if (isDiv(Op) && (B == '0)) begin
              wHi       <= A;
              wLo       <= QUOT_ONES[DATA_W-1:0];
              dz        <= 1'b1;
              DivByZero <= 1'b1;
              state     <= FIX;
            end else begin
              wLo   <= isDiv(Op) ? absA : absB;
              opnd  <= isDiv(Op) ? absB : absA;
              cnt   <= CNT_W'(DATA_W);
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (Cancel) state <= IDLE;
          else begin
            wHi <= nHi;
            wLo <= nLo;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          Done  <= ~Cancel;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fixWr = (state == FIX) & ~Cancel;
  assign hiWe  = fixWr | (accept & (Op == OP_MTHI));
  assign loWe  = fixWr | (accept & (Op == OP_MTLO));
  assign hiD   = fixWr ? fixHi : A;
  assign loD   = fixWr ? fixLo : A;

  muldiv_hilo_reg #(.DATA_W(DATA_W)) uHiLo (
    .Clock(Clock), .Reset(Reset), .hiWe(hiWe), .loWe(loWe),
    .hiD(hiD), .loD(loD), .Hi(Hi), .Lo(Lo)
  );
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (DATA_W=32); MADD checks follow MULDIV_MADD_EN.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clock = 1'b0, Reset, Start, Cancel, RdReq, RdSel;
  logic [3:0]  Op;
  logic [31:0] A, B, ReadData, Hi, Lo;
  logic        Busy, Stall, Done, DivByZero;

  int nChk = 0, nFail = 0;
  logic [63:0] sbQ[$];
  logic [31:0] shHi = '0, shLo = '0;

  always #5 Clock = ~Clock;

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Cancel(Cancel), .Op(Op),
    .A(A), .B(B), .RdReq(RdReq), .RdSel(RdSel), .ReadData(ReadData),
    .Busy(Busy), .Stall(Stall), .Done(Done), .DivByZero(DivByZero),
    .Hi(Hi), .Lo(Lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] sa, sbv;
    logic signed [31:0] a32, b32, q, r;
    sa = $signed(a); sbv = $signed(b); a32 = $signed(a); b32 = $signed(b);
    case (op)
      OP_MULT:  return sa * sbv;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = a32 / b32; r = a32 % b32;
        return {r, q};
      end
      OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_MADD:  return hl + sa * sbv;
      OP_MADDU: return hl + {32'b0, a} * {32'b0, b};
      OP_MSUB:  return hl - sa * sbv;
      OP_MSUBU: return hl - {32'b0, a} * {32'b0, b};
      default:  return hl;
    endcase
  endfunction

  // Pop one expectation per Done pulse; a Done with nothing pending is an error.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && Done === 1'b1) begin
      if (sbQ.size() == 0) chk("spuriousDone", 1, 0);
      else begin
        logic [63:0] e;
        e = sbQ.pop_front();
        chk("sbHi", Hi, e[63:32]);
        chk("sbLo", Lo, e[31:0]);
      end
    end
  end

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int expLat, input bit rd, input bit poke);
    logic [63:0] e;
    int k;
    bit busyOk, stallOk;
    e = model(op, a, b, {shHi, shLo});
    @(negedge Clock);
    Start = 1; Op = op; A = a; B = b; RdReq = rd; RdSel = 1;
    sbQ.push_back(e);
    shHi = e[63:32]; shLo = e[31:0];
    @(negedge Clock);
    Start = 0;
    k = 1; busyOk = 1; stallOk = 1;
    while (Done !== 1'b1 && k < 100) begin
      if (Busy !== 1'b1) busyOk = 0;
      if (rd && Stall !== 1'b1) stallOk = 0;
      if (poke && k == 5) begin Start = 1; Op = OP_MTHI; A = 32'hDEAD_BEEF; end
      else Start = 0;
      @(negedge Clock);
      k++;
    end
    Start = 0;
    chk("latency", k, expLat);
    chk("busyWhileRunning", busyOk, 1);
    chk("busyAtDone", Busy, 0);
    if (rd) begin
      chk("stallWhileRunning", stallOk, 1);
      chk("readDataHi", ReadData, e[63:32]);
    end
    RdReq = 0;
  endtask

  task automatic moveTo(input logic [3:0] op, input logic [31:0] a);
    @(negedge Clock);
    Start = 1; Op = op; A = a;
    @(negedge Clock);
    Start = 0;
    if (op == OP_MTHI) shHi = a; else shLo = a;
    chk("mtBusy", Busy, 0);
    chk("mtHi", Hi, shHi);
    chk("mtLo", Lo, shLo);
  endtask

  initial begin
    Reset = 0; Start = 0; Cancel = 0; RdReq = 0; RdSel = 0; Op = '0; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    chk("rstHi", Hi, 0); chk("rstLo", Lo, 0); chk("rstBusy", Busy, 0);
    chk("rstDone", Done, 0); chk("rstDbz", DivByZero, 0); chk("rstStall", Stall, 0);
    Reset = 1;

    runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, 0, 0);
    chk("multHi", Hi, 32'hFFFF_FFFF); chk("multLo", Lo, 32'hFFFF_FFF1);
    runOp(OP_DIV,  32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    chk("divLo", Lo, 32'hFFFF_FFFD); chk("divHi", Hi, 32'hFFFF_FFFF);
    runOp(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    chk("divuLo", Lo, 32'h7FFF_FFFC); chk("divuHi", Hi, 32'h0000_0001);
    runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0);
    chk("minDivDbz", DivByZero, 0);

    runOp(OP_DIVU, 32'd10, 32'd0, 2, 0, 0);
    chk("dbzLo", Lo, 32'hFFFF_FFFF); chk("dbzHi", Hi, 32'h0000_000A);
    chk("dbzFlag", DivByZero, 1);
    moveTo(OP_MTLO, 32'h0000_1234);
    chk("dbzCleared", DivByZero, 0);
    runOp(OP_DIV, 32'hFFFF_FFFB, 32'd0, 2, 0, 0);
    chk("dbzSignedFlag", DivByZero, 1);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      if (i[0]) b = b >> 20;
      runOp(op, a, b, (isDiv(op) && b == 0) ? 2 : 34, 0, 0);
    end

    // RdReq held through the op, plus a Start poked mid-run that must be ignored
    runOp(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 34, 1, 1);

    @(negedge Clock);
    Start = 1; Op = OP_MULTU; A = '1; B = '1;
    @(negedge Clock);
    Start = 0;
    repeat (9) @(negedge Clock);
    Cancel = 1;
    @(negedge Clock);
    Cancel = 0;
    chk("cancelBusy", Busy, 0);
    repeat (40) @(negedge Clock);
    chk("cancelHi", Hi, shHi); chk("cancelLo", Lo, shLo);

    @(negedge Clock);
    Start = 1; Cancel = 1; Op = OP_MULT; A = 32'd3; B = 32'd3;
    @(negedge Clock);
    Start = 0; Cancel = 0;
    chk("cancelWinsBusy", Busy, 0);

    @(negedge Clock);
    Start = 1; Op = 4'hF; A = 32'h5555_5555;
    @(negedge Clock);
    Start = 0;
    chk("undefBusy", Busy, 0);
    repeat (3) @(negedge Clock);
    chk("undefHi", Hi, shHi); chk("undefLo", Lo, shLo);

    moveTo(OP_MTHI, 32'h0);
    moveTo(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
    runOp(OP_MADDU, 32'd1, 32'd1, 34, 0, 0);
    chk("madduHi", Hi, 32'h1); chk("madduLo", Lo, 32'h0);
    runOp(OP_MSUB, 32'hFFFF_FFFE, 32'd3, 34, 0, 0);
`else
    @(negedge Clock);
    Start = 1; Op = OP_MADDU; A = 32'd1; B = 32'd1;
    @(negedge Clock);
    Start = 0;
    chk("madduOffBusy", Busy, 0);
    repeat (40) @(negedge Clock);
    chk("madduOffHi", Hi, 32'h0); chk("madduOffLo", Lo, 32'hFFFF_FFFF);
`endif

    repeat (3) @(negedge Clock);
    chk("sbEmpty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
